au_op_sequencer: RTL and testbench
==================================

Name: au_op_sequencer

Overview:
- Command-side initiator for the registered 8-bit arithmetic unit.
- Accepts one signed-operand command at a time on a valid/ready interface and drives the unit's operand and select inputs. It captures the unit's output one cycle later and returns the result on a valid/ready response interface.
- Adds a multi-step signed MUL. MUL is built from repeated unit additions plus a final unit negation.
- Sits between the top-level control FSM and the arithmetic unit instance.

Parameters:
- W, 8, operand/result width; must match the arithmetic unit (fixed at 8 in this design).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
- cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 OP2, 3 OP3, 4 MUL, 5-7 illegal.
- cmd_a  in  W  operand A, two's complement.
- cmd_b  in  W  operand B, two's complement.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  W  result, two's complement, truncated to W bits.
- rsp_err  out  1  illegal opcode flag; qualified by rsp_valid.
- au_a  out  W  arithmetic unit operand A.
- au_b  out  W  arithmetic unit operand B.
- au_sel  out  2  arithmetic unit select.
- au_out  in  W  arithmetic unit result, valid the cycle after au_a/au_b/au_sel are presented.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all internal registers 0.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - au_a=0, au_b=0, au_sel=2'b00.
  - cmd_ready=1 once rst_n deasserts.
  - Reset mid-operation abandons the command; no response is produced.
- Unit contract relied on:
  - sel 00 gives out=A+B.
  - sel 01 gives out=A-B.
  - Latency 1 cycle in both cases.
  - Ops 2/3 are passed through opaquely.
- au_a/au_b/au_sel are registered and driven only in ISSUE-type states; 0/0/00 in all other states.
- Accept: cmd_valid & cmd_ready at edge E latches op, a, b.
- States:
  - IDLE: cmd_ready=1. On accept:
    - op 0-3 -> ISSUE.
    - op 4 with b==0 -> RESP with data 0.
    - op 4 otherwise -> MUL_ISSUE with acc=0, cnt=|b|, mag=|a|, neg=a[W-1]^b[W-1].
    - op 5-7 -> RESP with err=1, data 0.
  - ISSUE: drive au_a=a, au_b=b, au_sel=op[1:0] -> WAIT.
  - WAIT: rsp_data<=au_out -> RESP. RESP is reached at edge E+2.
  - MUL_ISSUE: au_a=acc, au_b=mag, au_sel=00 -> MUL_WAIT.
  - MUL_WAIT: acc<=au_out, cnt<=cnt-1.
    - If cnt==1: go NEG_ISSUE if neg, else RESP with rsp_data=au_out.
    - Otherwise go MUL_ISSUE.
  - NEG_ISSUE: au_a=0, au_b=acc, au_sel=01 -> NEG_WAIT.
  - NEG_WAIT: rsp_data<=au_out -> RESP.
  - RESP: rsp_valid=1. Hold rsp_data/rsp_err stable until rsp_ready; on rsp_valid&rsp_ready -> IDLE, clearing rsp_err.
- MUL latency with n=|b|: RESP at E+2n without neg, E+2n+2 with neg. Worst case n=128 gives E+258.
- Width rules:
  - |x| is computed as two's complement negation mod 2^W, so |-128|=0x80 (unsigned 128).
  - cnt is W bits wide.
  - MUL result is the low W bits of the signed product.
- cmd_ready=0 in every non-IDLE state. Commands offered while busy are ignored and must be held by the source.
- rsp_ready is ignored outside RESP.
- Returning RESP -> IDLE allows a new accept on the next edge (one idle cycle minimum between responses).

Decomposition:
- Shared package au_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_2=2, OP_3=3, OP_MUL=4;
  - unit select constants SEL_ADD=2'b00, SEL_SUB=2'b01;
  - state encoding localparams (IDLE, ISSUE, WAIT, MUL_ISSUE, MUL_WAIT, NEG_ISSUE, NEG_WAIT, RESP).
- No sub-module; single FSM plus datapath registers.
- The arithmetic unit is instantiated alongside this block by the parent, not inside it.

Test Plan:
- ADD a=0x05, b=0x03, accept at E, rsp_ready=1 -> au_sel=00 during E..E+1; rsp_valid at E+2, rsp_data=0x08, rsp_err=0.
- SUB a=0x10, b=0x20 -> rsp_data=0xF0 at E+2; then rsp_ready held low 5 cycles -> rsp_valid and 0xF0 stable, cmd_ready=0 throughout.
- MUL a=0x07, b=0xFD (7 x -3) -> three add iterations (acc 7, 14, 21), then negation; rsp_valid at E+8, rsp_data=0xEB.
- MUL a=0x80, b=0x01 -> rsp_data=0x80 at E+4. MUL a=0x25, b=0x00 -> rsp_data=0x00 at E.
- Illegal op 6 -> rsp_valid at E, rsp_err=1, rsp_data=0x00; next ADD 0x01+0x01 returns 0x02 with rsp_err=0.
- Assert rst_n low during MUL_WAIT of a MUL a=0x03, b=0x40 -> outputs 0 immediately; no rsp_valid; after release cmd_ready=1 and a fresh ADD completes normally.

Source files
------------

// File: rtl/au_pkg.sv
`default_nettype none
// ============================================================================
// Module      : au_pkg
// Description : Opcodes, unit selects and state encoding for au_op_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package au_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_2   = 3'd2;
    localparam logic [2:0] OP_3   = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT      = 3'd2;
    localparam logic [2:0] S_MUL_ISSUE = 3'd3;
    localparam logic [2:0] S_MUL_WAIT  = 3'd4;
    localparam logic [2:0] S_NEG_ISSUE = 3'd5;
    localparam logic [2:0] S_NEG_WAIT  = 3'd6;
    localparam logic [2:0] S_RESP      = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_ISSUE     = S_ISSUE,
        ST_WAIT      = S_WAIT,
        ST_MUL_ISSUE = S_MUL_ISSUE,
        ST_MUL_WAIT  = S_MUL_WAIT,
        ST_NEG_ISSUE = S_NEG_ISSUE,
        ST_NEG_WAIT  = S_NEG_WAIT,
        ST_RESP      = S_RESP
    } state_t;

endpackage
`default_nettype wire

// File: rtl/au_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : au_op_sequencer
// Description : Command/response sequencer driving the registered 8-bit
//               arithmetic unit; builds signed MUL from repeated additions.
// Revision    : 1.0 - initial release
// ============================================================================
module au_op_sequencer
    import au_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic [W-1:0] au_a,
    output logic [W-1:0] au_b,
    output logic [1:0]   au_sel,
    input  logic [W-1:0] au_out
);

    state_t         r_state;
    logic [W-1:0]   r_cnt;
    logic [W-1:0]   r_mag;
    logic           r_neg;
    logic           r_rsp_valid;
    logic [W-1:0]   r_rsp_data;
    logic           r_rsp_err;
    logic [W-1:0]   r_au_a;
    logic [W-1:0]   r_au_b;
    logic [1:0]     r_au_sel;

    // Magnitudes wrap mod 2^W, so the most negative operand maps to 2^(W-1).
    logic [W-1:0]   w_abs_a;
    logic [W-1:0]   w_abs_b;

    assign w_abs_a = cmd_a[W-1] ? (~cmd_a) + W'(1) : cmd_a;
    assign w_abs_b = cmd_b[W-1] ? (~cmd_b) + W'(1) : cmd_b;

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign au_a      = r_au_a;
    assign au_b      = r_au_b;
    assign au_sel    = r_au_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mag       <= '0;
            r_neg       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_au_a      <= '0;
            r_au_b      <= '0;
            r_au_sel    <= SEL_ADD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_ADD, OP_SUB, OP_2, OP_3: begin
                                r_au_a   <= cmd_a;
                                r_au_b   <= cmd_b;
                                r_au_sel <= cmd_op[1:0];
                                r_state  <= ST_ISSUE;
                            end
                            OP_MUL: begin
                                if (cmd_b == '0) begin
                                    r_rsp_data  <= '0;
                                    r_rsp_err   <= 1'b0;
                                    r_rsp_valid <= 1'b1;
                                    r_state     <= ST_RESP;
                                end else begin
                                    // Accumulator starts at zero and lives in au_a.
                                    r_cnt    <= w_abs_b;
                                    r_mag    <= w_abs_a;
                                    r_neg    <= cmd_a[W-1] ^ cmd_b[W-1];
                                    r_au_a   <= '0;
                                    r_au_b   <= w_abs_a;
                                    r_au_sel <= SEL_ADD;
                                    r_state  <= ST_MUL_ISSUE;
                                end
                            end
                            default: begin
                                r_rsp_data  <= '0;
                                r_rsp_err   <= 1'b1;
                                r_rsp_valid <= 1'b1;
                                r_state     <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    r_au_a   <= '0;
                    r_au_b   <= '0;
                    r_au_sel <= SEL_ADD;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_rsp_data  <= au_out;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_MUL_ISSUE: begin
                    r_au_a   <= '0;
                    r_au_b   <= '0;
                    r_au_sel <= SEL_ADD;
                    r_state  <= ST_MUL_WAIT;
                end
                ST_MUL_WAIT: begin
                    r_cnt <= r_cnt - W'(1);
                    if (r_cnt == W'(1)) begin
                        if (r_neg) begin
                            r_au_a   <= '0;
                            r_au_b   <= au_out;
                            r_au_sel <= SEL_SUB;
                            r_state  <= ST_NEG_ISSUE;
                        end else begin
                            r_rsp_data  <= au_out;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end else begin
                        r_au_a   <= au_out;
                        r_au_b   <= r_mag;
                        r_au_sel <= SEL_ADD;
                        r_state  <= ST_MUL_ISSUE;
                    end
                end
                ST_NEG_ISSUE: begin
                    r_au_a   <= '0;
                    r_au_b   <= '0;
                    r_au_sel <= SEL_ADD;
                    r_state  <= ST_NEG_WAIT;
                end
                ST_NEG_WAIT: begin
                    r_rsp_data  <= au_out;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_au_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_au_op_sequencer
// Description : Self-checking bench for au_op_sequencer with a registered
//               arithmetic unit model and a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_au_op_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic [W-1:0] au_a;
    logic [W-1:0] au_b;
    logic [1:0]   au_sel;
    logic [W-1:0] au_out = '0;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] obs_au_a;
    logic [W-1:0] obs_au_b;
    logic [1:0]   obs_au_sel;

    always #5 clk = ~clk;

    au_op_sequencer #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .au_a      (au_a),
        .au_b      (au_b),
        .au_sel    (au_sel),
        .au_out    (au_out)
    );

    // Registered arithmetic unit; selects 2/3 are arbitrary opaque functions.
    always @(posedge clk) begin
        case (au_sel)
            2'b00:   au_out <= au_a + au_b;
            2'b01:   au_out <= au_a - au_b;
            2'b10:   au_out <= au_a & au_b;
            default: au_out <= au_a ^ au_b;
        endcase
    end

    function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, output logic [W-1:0] d,
                                      output logic e, output int l);
        int sa, sb, n;
        sa = int'($signed(a));
        sb = int'($signed(b));
        d = '0;
        e = 1'b0;
        l = 2;
        case (op)
            3'd0: d = W'(sa + sb);
            3'd1: d = W'(sa - sb);
            3'd2: d = a & b;
            3'd3: d = a ^ b;
            3'd4: begin
                if (sb == 0) begin
                    l = 0;
                end else begin
                    n = (sb < 0) ? -sb : sb;
                    d = W'(sa * sb);
                    l = 2 * n + (((sa < 0) != (sb < 0)) ? 2 : 0);
                end
            end
            default: begin
                e = 1'b1;
                l = 0;
            end
        endcase
    endfunction

    task automatic send_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        obs_au_a   = au_a;
        obs_au_b   = au_b;
        obs_au_sel = au_sel;
    endtask

    task automatic wait_rsp(output int l, output logic [W-1:0] d, output logic e);
        l = 0;
        while (rsp_valid !== 1'b1 && l < 400) begin
            @(posedge clk);
            #1;
            l++;
        end
        d = rsp_data;
        e = rsp_err;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({rsp_valid, rsp_err, rsp_data, au_a, au_b, au_sel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b err=%b data=%h au_a=%h au_b=%h sel=%b required all 0",
                     rsp_valid, rsp_err, rsp_data, au_a, au_b, au_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_add();
        int l;
        logic [W-1:0] d;
        logic e;
        send_cmd(3'd0, 8'h05, 8'h03);
        checks++;
        if ({obs_au_sel, obs_au_a, obs_au_b} !== {2'b00, 8'h05, 8'h03}) begin
            errors++;
            $display("FAIL add_issue: sel=%b a=%h b=%h required 00 05 03", obs_au_sel, obs_au_a, obs_au_b);
        end
        wait_rsp(l, d, e);
        checks++;
        if (l !== 2 || d !== 8'h08 || e !== 1'b0) begin
            errors++;
            $display("FAIL add_rsp: lat=%0d data=%h err=%b required 2 08 0", l, d, e);
        end
        release_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_release: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_sub_backpressure();
        int l;
        logic [W-1:0] d;
        logic e;
        send_cmd(3'd1, 8'h10, 8'h20);
        checks++;
        if (obs_au_sel !== 2'b01) begin
            errors++;
            $display("FAIL sub_issue_sel: got %b required 01", obs_au_sel);
        end
        wait_rsp(l, d, e);
        checks++;
        if (l !== 2 || d !== 8'hF0 || e !== 1'b0) begin
            errors++;
            $display("FAIL sub_rsp: lat=%0d data=%h err=%b required 2 F0 0", l, d, e);
        end
        // Offer a command while busy; it must be ignored.
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_a     = 8'h01;
        cmd_b     = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'hF0 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL sub_stall[%0d]: valid=%b data=%h cmd_ready=%b required 1 F0 0",
                         i, rsp_valid, rsp_data, cmd_ready);
            end
        end
        cmd_valid = 1'b0;
        release_rsp();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL sub_busy_ignored: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] ta [4] = '{8'h07, 8'h80, 8'h25, 8'h03};
        logic [W-1:0] tb [4] = '{8'hFD, 8'h01, 8'h00, 8'h05};
        logic [W-1:0] td [4] = '{8'hEB, 8'h80, 8'h00, 8'h0F};
        int           tl [4] = '{8, 4, 0, 10};
        int l;
        logic [W-1:0] d;
        logic e;
        for (int i = 0; i < 4; i++) begin
            send_cmd(3'd4, ta[i], tb[i]);
            wait_rsp(l, d, e);
            checks++;
            if (l !== tl[i] || d !== td[i] || e !== 1'b0) begin
                errors++;
                $display("FAIL mul[%0d] %h*%h: lat=%0d data=%h err=%b required %0d %h 0",
                         i, ta[i], tb[i], l, d, e, tl[i], td[i]);
            end
            release_rsp();
        end
    endtask

    task automatic test_illegal();
        int l;
        logic [W-1:0] d;
        logic e;
        send_cmd(3'd6, 8'h5A, 8'hA5);
        wait_rsp(l, d, e);
        checks++;
        if (l !== 0 || d !== 8'h00 || e !== 1'b1) begin
            errors++;
            $display("FAIL illegal_rsp: lat=%0d data=%h err=%b required 0 00 1", l, d, e);
        end
        release_rsp();
        send_cmd(3'd0, 8'h01, 8'h01);
        wait_rsp(l, d, e);
        checks++;
        if (l !== 2 || d !== 8'h02 || e !== 1'b0) begin
            errors++;
            $display("FAIL after_illegal_add: lat=%0d data=%h err=%b required 2 02 0", l, d, e);
        end
        release_rsp();
    endtask

    task automatic test_random();
        int l, el;
        logic [W-1:0] d, ed, a, b;
        logic e, ee;
        logic [2:0] op;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            b  = W'($urandom);
            ref_model(op, a, b, ed, ee, el);
            send_cmd(op, a, b);
            wait_rsp(l, d, e);
            checks++;
            if (l !== el || d !== ed || e !== ee) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: lat=%0d data=%h err=%b required %0d %h %b",
                         i, op, a, b, l, d, e, el, ed, ee);
            end
            release_rsp();
        end
    endtask

    task automatic test_reset_midop();
        int l;
        logic [W-1:0] d;
        logic e;
        int seen;
        send_cmd(3'd4, 8'h03, 8'h40);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_data, au_a, au_b, au_sel} !== '0) begin
            errors++;
            $display("FAIL midop_reset_outputs: valid=%b err=%b data=%h au_a=%h au_b=%h sel=%b required all 0",
                     rsp_valid, rsp_err, rsp_data, au_a, au_b, au_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midop_after_release: %0d cycles with rsp_valid=1 or cmd_ready=0, required 0", seen);
        end
        send_cmd(3'd0, 8'h11, 8'h22);
        wait_rsp(l, d, e);
        checks++;
        if (l !== 2 || d !== 8'h33 || e !== 1'b0) begin
            errors++;
            $display("FAIL midop_fresh_add: lat=%0d data=%h err=%b required 2 33 0", l, d, e);
        end
        release_rsp();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_backpressure();
        test_mul();
        test_illegal();
        test_random();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
